// File: rtl/ics_pkg.sv
// Shared constants for the ics test-access block and its functional unit.
// State codes of the 16-state FSM plus the TAP instruction opcodes.
package ics_pkg;

  typedef enum logic [3:0] {
    STATE_0 = 4'h0,
    STATE_1 = 4'h1,
    STATE_2 = 4'h2,
    STATE_3 = 4'h3,
    STATE_4 = 4'h4,
    STATE_5 = 4'h5,
    STATE_6 = 4'h6,
    STATE_7 = 4'h7,
    STATE_8 = 4'h8,
    STATE_9 = 4'h9,
    STATE_A = 4'hA,
    STATE_B = 4'hB,
    STATE_C = 4'hC,
    STATE_D = 4'hD,
    STATE_E = 4'hE,
    STATE_F = 4'hF
  } state_t;

  localparam logic [3:0] BYPASS   = 4'hF;
  localparam logic [3:0] SAMPLE   = 4'h1;
  localparam logic [3:0] EXTEST   = 4'h2;
  localparam logic [3:0] INTEST   = 4'h3;
  localparam logic [3:0] RUNBIST  = 4'h4;
  localparam logic [3:0] CLAMP    = 4'h5;
  localparam logic [3:0] IDCODE   = 4'h7;
  localparam logic [3:0] USERCODE = 4'h8;
  localparam logic [3:0] HIGHZ    = 4'h9;

endpackage

// File: rtl/ics_functional_unit_if.sv
// Input vector / state output bundle of the ics functional unit.
// The stimulus side is master, the FSM is slave.
interface ics_functional_unit_if;

  logic [3:0] X;
  logic [3:0] Yin;

  modport master (
    output X,
    input  Yin
  );

  modport slave (
    input  X,
    output Yin
  );

endinterface

// File: rtl/ics_functional_unit.sv
// Core FSM behind the ics TAP: 16 states stepped by a 4-bit input.
// Yin is the registered state; TLR forces STATE_0 synchronously.
module ics_functional_unit
  import ics_pkg::*;
(
  input  logic                        clk,
  input  logic                        TLR,
  ics_functional_unit_if.slave        fu
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (TLR) begin
      state_q <= STATE_0;
    end else begin
      state_q <= state_d;
    end
  end

  // Unlisted or non-binary X falls to a default, so the state holds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STATE_0: begin
        case (fu.X)
          4'h2:    state_d = STATE_1;
          default: state_d = state_q;
        endcase
      end
      STATE_1: begin
        case (fu.X)
          4'h2:    state_d = STATE_B;
          default: state_d = state_q;
        endcase
      end
      STATE_2: begin
        case (fu.X)
          4'h0:    state_d = STATE_9;
          default: state_d = state_q;
        endcase
      end
      STATE_4: begin
        case (fu.X)
          4'h7:    state_d = STATE_C;
          default: state_d = state_q;
        endcase
      end
      STATE_8: begin
        case (fu.X)
          4'hF:    state_d = STATE_B;
          default: state_d = state_q;
        endcase
      end
      STATE_9: begin
        case (fu.X)
          4'h0:    state_d = STATE_4;
          default: state_d = state_q;
        endcase
      end
      STATE_B: begin
        case (fu.X)
          4'hC:    state_d = STATE_8;
          4'hE:    state_d = STATE_C;
          default: state_d = state_q;
        endcase
      end
      STATE_C: begin
        case (fu.X)
          4'hE:    state_d = STATE_2;
          4'h2:    state_d = STATE_E;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  assign fu.Yin = state_q;

endmodule

// File: tb/tb_ics_functional_unit.sv
// Bench for ics_functional_unit: vector table plus scoreboard queue.
// Hand sequences cover the unknown-input step.
module tb_ics_functional_unit;

  typedef struct {
    logic       tlr;
    logic [3:0] x;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  logic clk;
  logic TLR;

  ics_functional_unit_if bus ();

  ics_functional_unit dut (
    .clk (clk),
    .TLR (TLR),
    .fu  (bus.slave)
  );

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         n_pass;
  int         n_tot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] nxt(input logic [3:0] s,
                                     input logic [3:0] x);
    case ({s, x})
      8'h02:   return 4'h1;
      8'h12:   return 4'hB;
      8'hBC:   return 4'h8;
      8'h8F:   return 4'hB;
      8'hBE:   return 4'hC;
      8'hCE:   return 4'h2;
      8'h20:   return 4'h9;
      8'h90:   return 4'h4;
      8'h47:   return 4'hC;
      8'hC2:   return 4'hE;
      default: return s;
    endcase
  endfunction

  task automatic check(input string nm, input logic [3:0] ex);
    n_tot++;
    if (bus.Yin !== ex)
      $display("FAIL %s: Yin=%h expected %h", nm, bus.Yin, ex);
    else
      n_pass++;
  endtask

  task automatic step(input logic t, input logic [3:0] x,
                      input logic [3:0] e, input string nm);
    logic [3:0] ex;
    @(negedge clk);
    TLR   = t;
    bus.X = x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    check(nm, ex);
  endtask

  task automatic add(input logic t, input logic [3:0] x,
                     input logic [3:0] e, input string nm);
    vec_t v;
    v.tlr = t;
    v.x   = x;
    v.exp = e;
    v.nm  = nm;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ex;
    logic [3:0] cur;
    n_pass = 0;
    n_tot  = 0;
    TLR    = 1'b1;
    bus.X  = 4'h0;

    add(1, 4'h0, 4'h0, "reset0");
    add(1, 4'h0, 4'h0, "reset1");
    add(0, 4'h2, 4'h1, "g0_2");
    add(0, 4'h2, 4'hB, "g1_2");
    add(0, 4'hC, 4'h8, "gB_C");
    add(0, 4'hF, 4'hB, "g8_F");
    add(0, 4'hE, 4'hC, "gB_E");
    add(0, 4'hE, 4'h2, "gC_E");
    add(0, 4'h0, 4'h9, "g2_0");
    add(0, 4'h0, 4'h4, "g9_0");
    add(0, 4'h7, 4'hC, "g4_7");
    add(0, 4'h2, 4'hE, "gC_2");
    add(0, 4'h5, 4'hE, "holdE_5");
    add(1, 4'h3, 4'h0, "reset2");
    add(0, 4'h0, 4'h0, "hold0_a");
    add(0, 4'h0, 4'h0, "hold0_b");
    add(0, 4'h0, 4'h0, "hold0_c");
    add(0, 4'h2, 4'h1, "to1");
    add(0, 4'h2, 4'hB, "toB");
    add(0, 4'h2, 4'hB, "holdB_2");
    add(0, 4'hE, 4'hC, "toC");
    add(1, 4'hE, 4'h0, "midrst");
    add(0, 4'h2, 4'h1, "after_rst");
    add(1, 4'h2, 4'h0, "prio0");
    add(1, 4'h2, 4'h0, "prio1");
    add(1, 4'h2, 4'h0, "prio2");
    add(1, 4'h2, 4'h0, "prio3");
    add(0, 4'h2, 4'h1, "p_to1");
    add(0, 4'h2, 4'hB, "p_toB");
    add(0, 4'hE, 4'hC, "p_toC");
    add(0, 4'hE, 4'h2, "p_to2");
    add(0, 4'h0, 4'h9, "p_to9");

    foreach (vecs[i]) begin
      if (nxt(4'h0, 4'h0) !== 4'h0 || vecs[i].tlr || 1'b1)
        step(vecs[i].tlr, vecs[i].x, vecs[i].exp, vecs[i].nm);
    end

    @(negedge clk);
    TLR   = 1'b0;
    bus.X = 4'bxxxx;
    ex    = $isunknown(bus.X) ? 4'h9 : nxt(4'h9, bus.X);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    check("unknown_hold", ex);
    n_tot++;
    if ($isunknown(bus.Yin))
      $display("FAIL unknown_clean: Yin=%b expected no X", bus.Yin);
    else
      n_pass++;
    cur = ex;

    step(0, 4'h0, nxt(cur, 4'h0), "after_unknown");

    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL sb_drain: left=%0d expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
